// File: rtl/d2_uop_sequencer.sv
// d2_uop_sequencer: second-stage decode. Takes one decoded instruction per
// handshake and expands it into 1..MAX_UOPS registered micro-ops, one per cycle.
module d2_uop_sequencer #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned MAX_UOPS = 4,
    parameter int unsigned CNT_W    = $clog2(MAX_UOPS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  pc_in,
    input  logic [XLEN-1:0]  instruction_in,
    input  logic [2:0]       opcode_format,
    input  logic [CNT_W-1:0] uop_count,
    input  logic             exception_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  uop,
    output logic [CNT_W-1:0] uop_idx,
    output logic             eoi,
    output logic [4:0]       dr,
    output logic [4:0]       sr1,
    output logic [4:0]       sr2,
    output logic [XLEN-1:0]  imm,
    output logic             use_imm,
    output logic [XLEN-1:0]  pc_out,
    output logic             exception_out
);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_ISSUE = 1'b1;

    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_UOPS);

    // State and effective uop count of the instruction being issued
    logic             state_q, state_d;
    logic [CNT_W-1:0] n_q, n_d;

    // Output register
    logic             valid_q, valid_d;
    logic [XLEN-1:0]  uop_q, uop_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             eoi_q, eoi_d;
    logic [4:0]       dr_q, dr_d;
    logic [4:0]       sr1_q, sr1_d;
    logic [4:0]       sr2_q, sr2_d;
    logic [XLEN-1:0]  imm_q, imm_d;
    logic             use_imm_q, use_imm_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic             exc_q, exc_d;

    logic [31:0]      ins32;
    logic [31:0]      imm32;
    logic             dec_use_imm;
    logic [XLEN-1:0]  cap_imm;
    logic [CNT_W-1:0] n_eff;
    logic [CNT_W-1:0] idx_next;
    logic             advance;
    logic             last;
    logic             capture;

    assign ins32    = instruction_in[31:0];
    assign advance  = !valid_q || out_ready;
    // Only meaningful in ST_ISSUE, where n_q is always >= 1
    assign last     = (idx_q == (n_q - CNT_ONE));
    assign idx_next = idx_q + CNT_ONE;
    assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_ISSUE) && last && advance);
    assign capture  = in_valid && in_ready && !flush;

    // Immediate decode of the incoming instruction; exceptions suppress the immediate
    always_comb begin
        imm32       = '0;
        dec_use_imm = 1'b0;
        case (opcode_format)
            FMT_I: begin
                imm32       = {{20{ins32[31]}}, ins32[31:20]};
                dec_use_imm = 1'b1;
            end
            FMT_S: begin
                imm32       = {{20{ins32[31]}}, ins32[31:25], ins32[11:7]};
                dec_use_imm = 1'b1;
            end
            FMT_B: begin
                imm32       = {{19{ins32[31]}}, ins32[31], ins32[7], ins32[30:25],
                               ins32[11:8], 1'b0};
                dec_use_imm = 1'b1;
            end
            FMT_U: begin
                imm32       = {ins32[31:12], 12'b0};
                dec_use_imm = 1'b1;
            end
            FMT_J: begin
                imm32       = {{11{ins32[31]}}, ins32[31], ins32[19:12], ins32[20],
                               ins32[30:21], 1'b0};
                dec_use_imm = 1'b1;
            end
            default: begin
                imm32       = '0;
                dec_use_imm = 1'b0;
            end
        endcase
        if (exception_in) begin
            imm32       = '0;
            dec_use_imm = 1'b0;
        end
    end

    // Widen to XLEN by replicating the sign bit (XLEN >= 32 keeps the count >= 1)
    assign cap_imm = {{(XLEN - 31){imm32[31]}}, imm32[30:0]};

    // Effective uop count: 0 -> 1, saturate at MAX_UOPS, exceptions collapse to one uop
    always_comb begin
        n_eff = uop_count;
        if (exception_in || (uop_count == '0)) begin
            n_eff = CNT_ONE;
        end else if (uop_count > CNT_MAX) begin
            n_eff = CNT_MAX;
        end
    end

    // Next-state: flush beats capture, capture beats advance
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        valid_d   = valid_q;
        uop_d     = uop_q;
        idx_d     = idx_q;
        eoi_d     = eoi_q;
        dr_d      = dr_q;
        sr1_d     = sr1_q;
        sr2_d     = sr2_q;
        imm_d     = imm_q;
        use_imm_d = use_imm_q;
        pc_d      = pc_q;
        exc_d     = exc_q;

        if (flush) begin
            state_d   = ST_IDLE;
            n_d       = '0;
            valid_d   = 1'b0;
            uop_d     = '0;
            idx_d     = '0;
            eoi_d     = 1'b0;
            dr_d      = '0;
            sr1_d     = '0;
            sr2_d     = '0;
            imm_d     = '0;
            use_imm_d = 1'b0;
            pc_d      = '0;
            exc_d     = 1'b0;
        end else if (capture) begin
            // First uop goes straight into the output register
            state_d   = ST_ISSUE;
            n_d       = n_eff;
            valid_d   = 1'b1;
            uop_d     = instruction_in;
            idx_d     = '0;
            eoi_d     = (n_eff == CNT_ONE);
            dr_d      = ins32[11:7];
            sr1_d     = ins32[19:15];
            sr2_d     = ins32[24:20];
            imm_d     = cap_imm;
            use_imm_d = dec_use_imm;
            pc_d      = pc_in;
            exc_d     = exception_in;
        end else if ((state_q == ST_ISSUE) && advance) begin
            if (last) begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end else begin
                // Payload fields are shared by all uops; only index and eoi move
                idx_d = idx_next;
                eoi_d = (idx_next == (n_q - CNT_ONE));
            end
        end
    end

    // State and output register update
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            n_q       <= '0;
            valid_q   <= 1'b0;
            uop_q     <= '0;
            idx_q     <= '0;
            eoi_q     <= 1'b0;
            dr_q      <= '0;
            sr1_q     <= '0;
            sr2_q     <= '0;
            imm_q     <= '0;
            use_imm_q <= 1'b0;
            pc_q      <= '0;
            exc_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            valid_q   <= valid_d;
            uop_q     <= uop_d;
            idx_q     <= idx_d;
            eoi_q     <= eoi_d;
            dr_q      <= dr_d;
            sr1_q     <= sr1_d;
            sr2_q     <= sr2_d;
            imm_q     <= imm_d;
            use_imm_q <= use_imm_d;
            pc_q      <= pc_d;
            exc_q     <= exc_d;
        end
    end

    assign out_valid     = valid_q;
    assign uop           = uop_q;
    assign uop_idx       = idx_q;
    assign eoi           = eoi_q;
    assign dr            = dr_q;
    assign sr1           = sr1_q;
    assign sr2           = sr2_q;
    assign imm           = imm_q;
    assign use_imm       = use_imm_q;
    assign pc_out        = pc_q;
    assign exception_out = exc_q;

endmodule
